// File: rtl/cmp_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial magnitude compare sequencer.
//   state_e     : sequencer state encoding
//   CASC_*      : bit positions inside the 3-bit cascade vector {G,E,L}
//   CASC_INIT   : cascade seed, "equal so far"
package cmp_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int CASC_G = 2;
  localparam int CASC_E = 1;
  localparam int CASC_L = 0;

  localparam logic [2:0] CASC_INIT = 3'b010;

endpackage

// File: rtl/cmp_seq_ctrl_if.sv
// Operand/result handshake bundle for cmp_seq_ctrl.
//   master : operand producer / result consumer (drives clr, in_valid, a, b,
//            is_signed, out_ready)
//   slave  : the sequencer (drives in_ready, out_valid, gt, eq, lt, busy)
interface cmp_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             gt;
  logic             eq;
  logic             lt;
  logic             busy;

  modport master (
    output clr, in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, gt, eq, lt, busy
  );

  modport slave (
    input  clr, in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, gt, eq, lt, busy
  );
endinterface

// File: rtl/cmp_seq_ctrl_comparator_4.sv
// 4-bit cascadable magnitude comparator cell (comparator_4).
//   a_i, b_i : nibbles to compare
//   casc_i   : {G,E,L} verdict of the less significant nibbles
//   casc_o   : {G,E,L} verdict including this nibble
// An unequal nibble decides on its own; an equal nibble passes the cascade through.
module cmp_seq_ctrl_comparator_4
  import cmp_seq_ctrl_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [2:0] casc_i,
  output logic [2:0] casc_o
);

  logic nib_gt, nib_eq, nib_lt;

  assign nib_gt = (a_i > b_i);
  assign nib_eq = (a_i == b_i);
  assign nib_lt = (a_i < b_i);

  assign casc_o[CASC_G] = nib_gt | (nib_eq & casc_i[CASC_G]);
  assign casc_o[CASC_E] = nib_eq & casc_i[CASC_E];
  assign casc_o[CASC_L] = nib_lt | (nib_eq & casc_i[CASC_L]);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Nibble-serial wide magnitude compare sequencer.
// Walks one comparator_4 cell across the operands LSB nibble first, carrying the
// {G,E,L} cascade in a register; result after WIDTH/4 RUN cycles.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of cmp_seq_ctrl_if (clr, operand and result handshakes)
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | waiting for operands, in_ready=1
//   RUN     | one nibble per cycle through the cell
//   DONE    | result held on gt/eq/lt until out_ready
module cmp_seq_ctrl
  import cmp_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  cmp_seq_ctrl_if.slave bus
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [2:0]        casc_q;
  logic              in_ready_q, out_valid_q, busy_q;
  logic              gt_q, eq_q, lt_q;

  logic [NIB-1:0][3:0] a_nib, b_nib;
  logic [2:0]          casc_d;

  assign a_nib = a_q;
  assign b_nib = b_q;

  cmp_seq_ctrl_comparator_4 u_cell (
    .a_i    (a_nib[cnt_q]),
    .b_i    (b_nib[cnt_q]),
    .casc_i (casc_q),
    .casc_o (casc_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      casc_q      <= CASC_INIT;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
    end else if (bus.clr) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      casc_q      <= CASC_INIT;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            // Flipping the sign bit maps two's complement order onto unsigned order.
            a_q        <= {bus.a[WIDTH-1] ^ bus.is_signed, bus.a[WIDTH-2:0]};
            b_q        <= {bus.b[WIDTH-1] ^ bus.is_signed, bus.b[WIDTH-2:0]};
            cnt_q      <= '0;
            casc_q     <= CASC_INIT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          casc_q <= casc_d;
          if (cnt_q == CNT_LAST) begin
            // Counter parks on the last nibble instead of wrapping.
            out_valid_q <= 1'b1;
            gt_q        <= casc_d[CASC_G];
            eq_q        <= casc_d[CASC_E];
            lt_q        <= casc_d[CASC_L];
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            gt_q        <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.gt        = gt_q;
  assign bus.eq        = eq_q;
  assign bus.lt        = lt_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
module tb_cmp_seq_ctrl;

  localparam int WIDTH = 16;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  cmp_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  cmp_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.is_signed = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  // Accepts one operand pair; returns after the accept edge (+1).
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("in_ready_timeout", 32'd0, 32'd1);
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = s;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  // Waits for out_valid, returns cycles counted from the accept edge.
  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic ack_and_check(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_ack_ov"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_ack_rdy"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic do_cmp(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [2:0] exp_gel);
    int cyc;
    send(a, b, s);
    wait_result(cyc);
    chk({tag, "_lat"}, cyc, 32'd4);
    chk({tag, "_res"}, {29'd0, bus.gt, bus.eq, bus.lt}, {29'd0, exp_gel});
    ack_and_check(tag);
  endtask

  initial begin
    int cyc;
    n_vec  = 0;
    n_miss = 0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_outs", {27'd0, bus.out_valid, bus.gt, bus.eq, bus.lt, bus.busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    // {gt,eq,lt}
    do_cmp("eq_1234", 16'h1234, 16'h1234, 1'b0, 3'b010);
    do_cmp("lt_lsb",  16'h0010, 16'h0011, 1'b0, 3'b001);
    do_cmp("lt_msb",  16'h1FFF, 16'h2000, 1'b0, 3'b001);
    do_cmp("gt_uns",  16'h8000, 16'h7FFF, 1'b0, 3'b100);
    do_cmp("lt_sgn",  16'h8000, 16'h7FFF, 1'b1, 3'b001);
    do_cmp("gt_sgn",  16'hFFFF, 16'hFFFE, 1'b1, 3'b100);
    do_cmp("gt_lsb",  16'h0001, 16'h0000, 1'b0, 3'b100);

    // Stall in DONE with stray in_valid pulses.
    send(16'h00A0, 16'h0050, 1'b0);
    wait_result(cyc);
    chk("stall_lat", cyc, 32'd4);
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = i[0];
      bus.a        = 16'h0000;
      bus.b        = 16'hFFFF;
      chk("stall_res", {28'd0, bus.out_valid, bus.gt, bus.eq, bus.lt}, 32'b1100);
      chk("stall_rdy", {31'd0, bus.in_ready}, 32'd0);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("stall_res_end", {28'd0, bus.out_valid, bus.gt, bus.eq, bus.lt}, 32'b1100);
    ack_and_check("stall");
    chk("stall_busy", {31'd0, bus.busy}, 32'd0);

    // clr at RUN cnt=2.
    send(16'h1234, 16'h0000, 1'b0);
    tick();
    tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("clr_ov", {31'd0, bus.out_valid}, 32'd0);
    chk("clr_rdy", {31'd0, bus.in_ready}, 32'd1);
    chk("clr_busy", {31'd0, bus.busy}, 32'd0);
    repeat (5) tick();
    chk("clr_no_result", {31'd0, bus.out_valid}, 32'd0);
    do_cmp("after_clr", 16'h0005, 16'h0003, 1'b0, 3'b100);

    // Async reset at RUN cnt=2.
    send(16'h0000, 16'h1234, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_rdy", {31'd0, bus.in_ready}, 32'd1);
    chk("arst_outs", {27'd0, bus.out_valid, bus.gt, bus.eq, bus.lt, bus.busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_cmp("after_rst", 16'h0005, 16'h0003, 1'b0, 3'b100);

    // clr beats a same-cycle input handshake.
    bus.a        = 16'h0007;
    bus.b        = 16'h0001;
    bus.in_valid = 1'b1;
    bus.clr      = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.clr      = 1'b0;
    chk("clr_prio_busy", {31'd0, bus.busy}, 32'd0);
    chk("clr_prio_rdy", {31'd0, bus.in_ready}, 32'd1);

    // clr beats a same-cycle output handshake; result must vanish.
    send(16'h0003, 16'h0009, 1'b0);
    wait_result(cyc);
    bus.out_ready = 1'b1;
    bus.clr       = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.clr       = 1'b0;
    chk("clr_done", {27'd0, bus.out_valid, bus.gt, bus.eq, bus.lt, bus.busy}, 32'd0);

    // out_ready while idle has no effect.
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    chk("idle_oready", {27'd0, bus.out_valid, bus.gt, bus.eq, bus.lt, bus.busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
